// File: rtl/stripe_tx_if.sv
// Byte-stream input and striped lane output bundle for the transmit scheduler.
interface stripe_tx_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned CNT_W     = 16
);
  logic [1:0]           cfg_lanes;
  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 in_last;
  logic                 in_ready;
  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] lane_wr;
  logic [DATA_W-1:0]    lane_data;
  logic                 lane_pad;
  logic                 busy;
  logic [CNT_W-1:0]     stripe_cnt;

  // Source and lane sinks side.
  modport master (
    output cfg_lanes, in_valid, in_data, in_last, lane_ready,
    input  in_ready, lane_wr, lane_data, lane_pad, busy, stripe_cnt
  );

  // Scheduler side.
  modport slave (
    input  cfg_lanes, in_valid, in_data, in_last, lane_ready,
    output in_ready, lane_wr, lane_data, lane_pad, busy, stripe_cnt
  );
endinterface

// File: rtl/stripe_tx_scheduler.sv
// Deals a byte stream round-robin over 1, 2 or 4 lanes and pads the final
// stripe of each packet so every lane ends on a stripe boundary.
module stripe_tx_scheduler #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       NUM_LANES = 4,
  parameter logic [DATA_W-1:0] PAD_BYTE  = 'hBC,
  parameter int unsigned       CNT_W     = 16
) (
  input logic        clk,
  input logic        reset,
  stripe_tx_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(NUM_LANES);

  typedef enum logic [1:0] {StIdle, StStripe, StPad} state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W:0]       n_act;
  logic [PTR_W:0]       n_cfg;
  logic [PTR_W:0]       n_cur;
  logic                 last_lane;
  logic                 xfer;
  logic [NUM_LANES-1:0] lane_wr;
  logic [DATA_W-1:0]    lane_data;
  logic                 lane_pad;
  logic                 busy;
  logic [CNT_W-1:0]     stripe_cnt;

  // Lane count decode; the packet's count is sampled from cfg only while idle.
  always_comb begin
    unique case (bus.cfg_lanes)
      2'b00:   n_cfg = (PTR_W+1)'(1);
      2'b01:   n_cfg = (PTR_W+1)'(2);
      default: n_cfg = (PTR_W+1)'(4);
    endcase
    n_cur     = (state == StIdle) ? n_cfg : n_act;
    last_lane = ({1'b0, ptr} == (n_cur - (PTR_W+1)'(1)));
  end

  assign bus.in_ready   = (state != StPad) && bus.lane_ready[ptr];
  assign xfer           = bus.in_valid && bus.in_ready;
  assign bus.lane_wr    = lane_wr;
  assign bus.lane_data  = lane_data;
  assign bus.lane_pad   = lane_pad;
  assign bus.busy       = busy;
  assign bus.stripe_cnt = stripe_cnt;

  // Scheduler FSM with registered lane strobes, data, busy and stripe count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      ptr        <= '0;
      n_act      <= (PTR_W+1)'(4);
      lane_wr    <= '0;
      lane_data  <= '0;
      lane_pad   <= 1'b0;
      busy       <= 1'b0;
      stripe_cnt <= '0;
    end else begin
      lane_wr  <= '0;
      lane_pad <= 1'b0;
      unique case (state)
        StIdle, StStripe: begin
          if (xfer) begin
            lane_wr   <= NUM_LANES'(1) << ptr;
            lane_data <= bus.in_data;
            n_act     <= n_cur;
            if (last_lane) begin
              stripe_cnt <= stripe_cnt + CNT_W'(1);
              ptr        <= '0;
              state      <= bus.in_last ? StIdle : StStripe;
              busy       <= ~bus.in_last;
            end else begin
              ptr   <= ptr + PTR_W'(1);
              state <= bus.in_last ? StPad : StStripe;
              busy  <= 1'b1;
            end
          end
        end
        StPad: begin
          if (bus.lane_ready[ptr]) begin
            lane_wr   <= NUM_LANES'(1) << ptr;
            lane_data <= PAD_BYTE;
            lane_pad  <= 1'b1;
            if (last_lane) begin
              stripe_cnt <= stripe_cnt + CNT_W'(1);
              ptr        <= '0;
              state      <= StIdle;
              busy       <= 1'b0;
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
          end
        end
        default: begin
          state <= StIdle;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
